axi_id_remap_tracker: RTL and testbench

Sits between an upstream AXI read master and the downstream fabric, directly in front of axi_id_pool.
- Each accepted AR gets a pool ID from axi_id_pool; the request is forwarded with that ID and the original master ID is stored in a per-pool-ID table.
- On R beats, the original ID is restored.
- On the RLAST handshake, the pool ID is returned to the pool.

---
 rtl/axi_id_remap_tracker.sv | 133 +++++++++++++
 tb/tb_axi_id_remap_tracker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_id_remap_tracker.sv
// AXI read-channel ID remapper: swaps upstream master IDs for pool IDs on AR
// and restores them on R, returning each pool ID on the RLAST handshake.
module axi_id_remap_tracker #(
    parameter int ID_WIDTH    = 4,
    parameter int ID_COUNT    = 1 << ID_WIDTH,
    parameter int UP_ID_WIDTH = 6,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    input  logic [UP_ID_WIDTH-1:0] s_arid,
    input  logic [ADDR_WIDTH-1:0]  s_araddr,
    input  logic [7:0]             s_arlen,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output logic [ID_WIDTH-1:0]    m_arid,
    output logic [ADDR_WIDTH-1:0]  m_araddr,
    output logic [7:0]             m_arlen,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  logic [ID_WIDTH-1:0]    m_rid,
    input  logic                   m_rlast,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    output logic [UP_ID_WIDTH-1:0] s_rid,
    output logic                   s_rlast,
    input  logic                   alloc_valid,
    output logic                   alloc_req,
    input  logic [ID_WIDTH-1:0]    alloc_id,
    output logic                   dealloc_req,
    output logic [ID_WIDTH-1:0]    dealloc_id,
    output logic [ID_WIDTH:0]      outstanding,
    output logic                   err_unmapped
);

    typedef enum logic {AR_IDLE, AR_HELD} ar_state_e;

    localparam logic [ID_WIDTH:0] OUT_MAX = (ID_WIDTH+1)'(ID_COUNT);

    ar_state_e                ar_state_q, ar_state_d;
    logic [ID_WIDTH-1:0]      m_arid_q, m_arid_d;
    logic [ADDR_WIDTH-1:0]    m_araddr_q, m_araddr_d;
    logic [7:0]               m_arlen_q, m_arlen_d;
    logic [ID_COUNT-1:0]      valid_q, valid_d;
    logic [UP_ID_WIDTH-1:0]   orig_q [ID_COUNT];
    logic [UP_ID_WIDTH-1:0]   orig_d [ID_COUNT];
    logic [ID_WIDTH:0]        outstanding_q, outstanding_d;
    logic                     err_unmapped_q, err_unmapped_d;

    logic rbeat, rfire, rid_mapped, arfire, dealloc_fire;

    // A returning RLAST blocks AR acceptance so the pool never sees alloc and dealloc together.
    always_comb begin
        rbeat        = m_rvalid && s_rready;
        rfire        = rbeat && m_rlast;
        rid_mapped   = valid_q[m_rid];
        s_arready    = alloc_valid && (ar_state_q == AR_IDLE || m_arready) && !rfire && reset_n;
        arfire       = s_arvalid && s_arready;
        dealloc_fire = rfire && rid_mapped && reset_n;
    end

    assign alloc_req    = arfire;
    assign dealloc_req  = dealloc_fire;
    assign dealloc_id   = m_rid;
    assign m_arvalid    = (ar_state_q == AR_HELD);
    assign m_arid       = m_arid_q;
    assign m_araddr     = m_araddr_q;
    assign m_arlen      = m_arlen_q;
    assign s_rvalid     = m_rvalid;
    assign m_rready     = s_rready;
    assign s_rlast      = m_rlast;
    assign s_rid        = rid_mapped ? orig_q[m_rid] : '0;
    assign outstanding  = outstanding_q;
    assign err_unmapped = err_unmapped_q;

    always_comb begin
        ar_state_d     = ar_state_q;
        m_arid_d       = m_arid_q;
        m_araddr_d     = m_araddr_q;
        m_arlen_d      = m_arlen_q;
        valid_d        = valid_q;
        orig_d         = orig_q;
        outstanding_d  = outstanding_q;
        err_unmapped_d = err_unmapped_q;

        case (ar_state_q)
            AR_IDLE: if (arfire) ar_state_d = AR_HELD;
            AR_HELD: if (m_arready && !arfire) ar_state_d = AR_IDLE;
            default: ar_state_d = AR_IDLE;
        endcase

        if (arfire) begin
            m_arid_d          = alloc_id;
            m_araddr_d        = s_araddr;
            m_arlen_d         = s_arlen;
            valid_d[alloc_id] = 1'b1;
            orig_d[alloc_id]  = s_arid;
            if (outstanding_q != OUT_MAX) outstanding_d = outstanding_q + 1'b1;
        end

        if (dealloc_fire) begin
            valid_d[m_rid] = 1'b0;
            if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
        end

        if (rbeat && !rid_mapped) err_unmapped_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ar_state_q     <= AR_IDLE;
            valid_q        <= '0;
            outstanding_q  <= '0;
            err_unmapped_q <= 1'b0;
        end else begin
            ar_state_q     <= ar_state_d;
            valid_q        <= valid_d;
            outstanding_q  <= outstanding_d;
            err_unmapped_q <= err_unmapped_d;
        end
    end

    // Payload and original-ID storage need no reset; they are qualified by state and valid bits.
    always_ff @(posedge clk) begin
        m_arid_q   <= m_arid_d;
        m_araddr_q <= m_araddr_d;
        m_arlen_q  <= m_arlen_d;
        orig_q     <= orig_d;
    end

endmodule

// File: tb/tb_axi_id_remap_tracker.sv
// Directed plus random bench for axi_id_remap_tracker, with a FIFO free-list pool
// and a transaction-level model of the remap table.
module tb_axi_id_remap_tracker;

    localparam int ID_WIDTH    = 4;
    localparam int ID_COUNT    = 16;
    localparam int UP_ID_WIDTH = 6;
    localparam int ADDR_WIDTH  = 32;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   s_arvalid, s_arready;
    logic [UP_ID_WIDTH-1:0] s_arid;
    logic [ADDR_WIDTH-1:0]  s_araddr;
    logic [7:0]             s_arlen;
    logic                   m_arvalid, m_arready;
    logic [ID_WIDTH-1:0]    m_arid;
    logic [ADDR_WIDTH-1:0]  m_araddr;
    logic [7:0]             m_arlen;
    logic                   m_rvalid, m_rready;
    logic [ID_WIDTH-1:0]    m_rid;
    logic                   m_rlast;
    logic                   s_rvalid, s_rready;
    logic [UP_ID_WIDTH-1:0] s_rid;
    logic                   s_rlast;
    logic                   alloc_valid, alloc_req;
    logic [ID_WIDTH-1:0]    alloc_id;
    logic                   dealloc_req;
    logic [ID_WIDTH-1:0]    dealloc_id;
    logic [ID_WIDTH:0]      outstanding;
    logic                   err_unmapped;

    axi_id_remap_tracker #(
        .ID_WIDTH(ID_WIDTH), .ID_COUNT(ID_COUNT),
        .UP_ID_WIDTH(UP_ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rlast(m_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rlast(s_rlast),
        .alloc_valid(alloc_valid), .alloc_req(alloc_req), .alloc_id(alloc_id),
        .dealloc_req(dealloc_req), .dealloc_id(dealloc_id),
        .outstanding(outstanding), .err_unmapped(err_unmapped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference state: AR output slot, table of original IDs, pool free list, counters.
    bit                     held_e;
    logic [ID_WIDTH-1:0]    arid_e;
    logic [ADDR_WIDTH-1:0]  addr_e;
    logic [7:0]             len_e;
    bit                     tbl_v [ID_COUNT];
    logic [UP_ID_WIDTH-1:0] tbl_o [ID_COUNT];
    int                     out_e;
    bit                     err_e;
    int                     free_q [$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        held_e = 1'b0;
        out_e  = 0;
        err_e  = 1'b0;
        free_q.delete();
        for (int i = 0; i < ID_COUNT; i++) begin
            tbl_v[i] = 1'b0;
            tbl_o[i] = '0;
            free_q.push_back(i);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check mid-cycle, then advance the model at the rising edge.
    task automatic applyStimulus(input bit rst_n, input bit arv, input logic [5:0] arid,
                                 input logic [31:0] addr, input logic [7:0] len, input bit marr,
                                 input bit rv, input logic [3:0] rid, input bit rl, input bit rr);
        bit rf, mapped, exp_ready, exp_alloc, exp_dealloc;
        reset_n     = rst_n;
        s_arvalid   = arv;
        s_arid      = arid;
        s_araddr    = addr;
        s_arlen     = len;
        m_arready   = marr;
        m_rvalid    = rv;
        m_rid       = rid;
        m_rlast     = rl;
        s_rready    = rr;
        alloc_valid = (free_q.size() > 0);
        alloc_id    = alloc_valid ? 4'(free_q[0]) : 4'd0;
        #1;
        rf          = rv && rr && rl;
        mapped      = tbl_v[rid];
        exp_ready   = alloc_valid && (!held_e || marr) && !rf && rst_n;
        exp_alloc   = arv && exp_ready;
        exp_dealloc = rf && mapped && rst_n;

        checkOutput("s_arready", 64'(s_arready), 64'(exp_ready));
        checkOutput("alloc_req", 64'(alloc_req), 64'(exp_alloc));
        checkOutput("dealloc_req", 64'(dealloc_req), 64'(exp_dealloc));
        if (exp_dealloc) checkOutput("dealloc_id", 64'(dealloc_id), 64'(rid));
        checkOutput("m_arvalid", 64'(m_arvalid), 64'(held_e));
        if (held_e) begin
            checkOutput("m_arid", 64'(m_arid), 64'(arid_e));
            checkOutput("m_araddr", 64'(m_araddr), 64'(addr_e));
            checkOutput("m_arlen", 64'(m_arlen), 64'(len_e));
        end
        checkOutput("s_rvalid", 64'(s_rvalid), 64'(rv));
        checkOutput("m_rready", 64'(m_rready), 64'(rr));
        checkOutput("s_rlast", 64'(s_rlast), 64'(rl));
        checkOutput("s_rid", 64'(s_rid), mapped ? 64'(tbl_o[rid]) : 64'd0);
        checkOutput("outstanding", 64'(outstanding), 64'(out_e));
        checkOutput("err_unmapped", 64'(err_unmapped), 64'(err_e));

        @(posedge clk);
        if (!rst_n) begin
            resetModel();
        end else begin
            if (rv && rr && !mapped) err_e = 1'b1;
            if (exp_alloc) begin
                held_e          = 1'b1;
                arid_e          = alloc_id;
                addr_e          = addr;
                len_e           = len;
                tbl_v[alloc_id] = 1'b1;
                tbl_o[alloc_id] = arid;
                void'(free_q.pop_front());
                if (out_e < ID_COUNT) out_e++;
            end else if (marr) begin
                held_e = 1'b0;
            end
            if (exp_dealloc) begin
                tbl_v[rid] = 1'b0;
                free_q.push_back(int'(rid));
                out_e--;
            end
        end
        @(negedge clk);
    endtask

    task automatic doAr(input logic [5:0] arid, input logic [31:0] addr);
        applyStimulus(1'b1, 1'b1, arid, addr, 8'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic doR(input logic [3:0] rid, input bit last, input bit arv);
        applyStimulus(1'b1, arv, 6'h3F, 32'hC000_0000, 8'd0, 1'b1, 1'b1, rid, last, 1'b1);
    endtask

    task automatic doIdle();
        applyStimulus(1'b1, 1'b0, 6'h00, 32'h0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b1, 6'h11, 32'h0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int live [$];
        bit arv, marr, rv, rl, rr, rst_n;
        logic [3:0] rid;

        reset_n = 1'b0; s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rlast = 1'b0; s_rready = 1'b0;
        alloc_valid = 1'b0; alloc_id = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetModel();

        $display("[TB] reset behaviour");
        doReset();
        checkOutput("reset_outstanding", 64'(outstanding), 64'd0);
        checkOutput("reset_m_arvalid", 64'(m_arvalid), 64'd0);

        $display("[TB] single transaction");
        applyStimulus(1'b1, 1'b1, 6'h2A, 32'h0000_1000, 8'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("single_m_arid", 64'(m_arid), 64'd0);
        checkOutput("single_m_araddr", 64'(m_araddr), 64'h1000);
        doR(4'd0, 1'b0, 1'b0);
        doR(4'd0, 1'b0, 1'b0);
        checkOutput("single_outstanding_1", 64'(outstanding), 64'd1);
        doR(4'd0, 1'b1, 1'b0);
        checkOutput("single_outstanding_0", 64'(outstanding), 64'd0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b1, 6'h05, 32'h0000_A000, 8'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 6'h06, 32'h0000_B000, 8'd4, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("bp_m_araddr", 64'(m_araddr), 64'hA000);
        checkOutput("bp_outstanding", 64'(outstanding), 64'd1);
        applyStimulus(1'b1, 1'b1, 6'h06, 32'h0000_B000, 8'd4, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        doIdle();

        $display("[TB] out-of-order and unmapped");
        doReset();
        doAr(6'h10, 32'h100);
        doAr(6'h11, 32'h200);
        doAr(6'h12, 32'h300);
        doR(4'd2, 1'b1, 1'b0);
        doR(4'd0, 1'b1, 1'b0);
        doR(4'd9, 1'b0, 1'b0);
        checkOutput("unmapped_err", 64'(err_unmapped), 64'd1);
        doR(4'd9, 1'b1, 1'b0);

        $display("[TB] collision");
        doAr(6'h23, 32'h400);
        doR(4'd3, 1'b0, 1'b0);
        doR(4'd3, 1'b1, 1'b1);
        doAr(6'h24, 32'h500);
        doAr(6'h25, 32'h600);
        doAr(6'h26, 32'h700);
        doIdle();
        checkOutput("pre_reset_outstanding", 64'(outstanding), 64'd4);

        $display("[TB] mid-operation reset");
        doReset();
        checkOutput("mid_reset_outstanding", 64'(outstanding), 64'd0);
        checkOutput("mid_reset_err", 64'(err_unmapped), 64'd0);
        doR(4'd1, 1'b0, 1'b0);
        doReset();

        $display("[TB] pool exhaustion");
        for (int i = 0; i < ID_COUNT; i++) doAr(6'(i + 32), 32'(i * 16));
        checkOutput("exhaust_m_arid", 64'(m_arid), 64'd15);
        for (int i = 0; i < 3; i++) doAr(6'h3E, 32'hFFFF_0000);
        checkOutput("exhaust_outstanding", 64'(outstanding), 64'd16);
        checkOutput("exhaust_alloc_valid_low", 64'(alloc_valid), 64'd0);
        doR(4'd7, 1'b1, 1'b1);
        doAr(6'h3E, 32'hFFFF_0000);
        checkOutput("exhaust_reuse_arid", 64'(m_arid), 64'd7);
        doReset();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 500; n++) begin
            live.delete();
            for (int i = 0; i < ID_COUNT; i++) if (tbl_v[i]) live.push_back(i);
            rst_n = ($urandom_range(0, 99) != 0);
            arv   = ($urandom_range(0, 1) == 1);
            marr  = ($urandom_range(0, 3) != 0);
            rv    = ($urandom_range(0, 2) != 0);
            rl    = ($urandom_range(0, 1) == 1);
            rr    = ($urandom_range(0, 3) != 0);
            if (live.size() > 0 && $urandom_range(0, 7) != 0)
                rid = 4'(live[$urandom_range(0, live.size() - 1)]);
            else
                rid = 4'($urandom_range(0, ID_COUNT - 1));
            applyStimulus(rst_n, arv, 6'($urandom), $urandom, 8'($urandom), marr, rv, rid, rl, rr);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
